// File: rtl/sound_player_pkg.sv
// Shared constants and FSM encoding for the sound player datapath.
// SD block geometry mirrors the constants used by the SD card reader.
package sound_player_pkg;

  localparam int SD_BLOCK_ADDR_BITS   = 32;
  localparam int SD_BLOCK_LENGHT_BITS = 9;
  localparam int SAMPLE_BITS          = 16;
  localparam int SAMPLES_PER_BLOCK    = 256;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_RECEIVE
  } state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead sample FIFO: head word is always visible on rdata.
// Pushes into a full FIFO are dropped unless a pop frees a slot in the same cycle.
module sample_fifo #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  logic signed [DW-1:0] wdata,
  output logic signed [DW-1:0] rdata,
  output logic                 empty,
  output logic [AW:0]          count
);

  logic signed [DW-1:0] mem [0:(1 << AW)-1];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 full;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (count == '0);
  assign full    = count[AW];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/sd_sample_stream.sv
// Pulls 512-byte SD blocks, packs little-endian byte pairs into signed PCM
// samples, buffers them and releases one sample per sample-rate tick.
module sd_sample_stream
  import sound_player_pkg::*;
#(
  parameter int CLK_DIV   = 1134,
  parameter int FIFO_AW   = 10,
  parameter int ADDR_BITS = SD_BLOCK_ADDR_BITS,
  parameter int IDX_BITS  = SD_BLOCK_LENGHT_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [ADDR_BITS-1:0]          start_block,
  input  logic                          card_ready,
  output logic                          read_trigger,
  output logic [ADDR_BITS-1:0]          block_addr,
  input  logic [7:0]                    data_in,
  input  logic [IDX_BITS-1:0]           data_idx,
  input  logic                          data_new,
  output logic signed [SAMPLE_BITS-1:0] sample_out,
  output logic                          sample_valid,
  output logic                          underrun,
  output logic [FIFO_AW:0]              fill_level
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);

  state_t                       state;
  state_t                       next_state;
  logic [DIV_W-1:0]             div;
  logic                         tick;
  logic                         push;
  logic                         flush;
  logic                         last_byte;
  logic                         fifo_empty;
  logic [7:0]                   lo_byte_p0;
  logic signed [SAMPLE_BITS-1:0] head;
  logic [FIFO_AW:0]             free_space;

  assign free_space = (FIFO_AW+1)'(1 << FIFO_AW) - fill_level;
  assign last_byte  = data_new && (data_idx == IDX_BITS'(2*SAMPLES_PER_BLOCK - 1));
  assign tick       = enable && (div == DIV_W'(CLK_DIV - 1));

  always_comb begin
    next_state   = state;
    read_trigger = 1'b0;
    flush        = 1'b0;
    push         = 1'b0;
    case (state)
      ST_IDLE: begin
        flush = !enable;
        if (enable && card_ready &&
            free_space >= (FIFO_AW+1)'(SAMPLES_PER_BLOCK))
          next_state = ST_REQUEST;
      end
      ST_REQUEST: begin
        read_trigger = 1'b1;
        next_state   = ST_RECEIVE;
      end
      ST_RECEIVE: begin
        // A block is always received to the end so the reader is never aborted.
        push = data_new && data_idx[0];
        if (last_byte) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      div          <= '0;
      block_addr   <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      state        <= next_state;
      sample_valid <= tick;
      if (!enable || tick) div <= '0;
      else                 div <= div + DIV_W'(1);
      if (!enable)   sample_out <= '0;
      else if (tick) sample_out <= fifo_empty ? '0 : head;
      if (tick && fifo_empty) underrun <= 1'b1;
      else if (flush)         underrun <= 1'b0;
      if (flush)
        block_addr <= start_block;
      else if (state == ST_RECEIVE && last_byte)
        block_addr <= block_addr + ADDR_BITS'(1);
    end
  end

  // p0: low byte of the pair waits here until its odd-index partner arrives
  always_ff @(posedge clk) begin
    if (state == ST_RECEIVE && data_new && !data_idx[0]) lo_byte_p0 <= data_in;
  end

  sample_fifo #(
    .AW (FIFO_AW),
    .DW (SAMPLE_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (tick),
    .flush (flush),
    .wdata ($signed({data_in, lo_byte_p0})),
    .rdata (head),
    .empty (fifo_empty),
    .count (fill_level)
  );

endmodule

// File: tb/tb_sd_sample_stream.sv
// Bench for sd_sample_stream: drives SD block bytes, scoreboards packed samples
// against the sample-tick output and checks request/flush/underrun behaviour.
module tb_sd_sample_stream;

  localparam int CLK_DIV = 8;
  localparam int FIFO_AW = 10;
  localparam int AB      = 32;
  localparam int IB      = 9;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable;
  logic [AB-1:0]        start_block;
  logic                 card_ready;
  logic                 read_trigger;
  logic [AB-1:0]        block_addr;
  logic [7:0]           data_in;
  logic [IB-1:0]        data_idx;
  logic                 data_new;
  logic signed [15:0]   sample_out;
  logic                 sample_valid;
  logic                 underrun;
  logic [FIFO_AW:0]     fill_level;

  always #5 clk = ~clk;

  sd_sample_stream #(
    .CLK_DIV   (CLK_DIV),
    .FIFO_AW   (FIFO_AW),
    .ADDR_BITS (AB),
    .IDX_BITS  (IB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .start_block  (start_block),
    .card_ready   (card_ready),
    .read_trigger (read_trigger),
    .block_addr   (block_addr),
    .data_in      (data_in),
    .data_idx     (data_idx),
    .data_new     (data_new),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .underrun     (underrun),
    .fill_level   (fill_level)
  );

  typedef struct {
    logic [15:0] s;
    longint      stamp;
  } ent_t;

  ent_t          sb[$];
  int            vectors    = 0;
  int            miscompares = 0;
  longint        cyc        = 0;
  int            trig_cnt   = 0;
  int            blk_seed   = 0;
  logic [AB-1:0] exp_addr;

  always @(posedge clk) cyc++;

  // Scoreboard: a sample pushed at edge k may be popped at edge k+1 or later.
  always @(negedge clk) begin
    logic [15:0] exp;
    if (read_trigger === 1'b1) trig_cnt++;
    if (rst === 1'b0 && sample_valid === 1'b1) begin
      vectors++;
      if (sb.size() > 0 && sb[0].stamp < cyc) begin
        exp = sb[0].s;
        void'(sb.pop_front());
        if (sample_out !== exp) begin
          miscompares++;
          $display("FAIL sample_pop: got %h, expected %h", sample_out, exp);
        end
      end else if (sample_out !== 16'h0 || underrun !== 1'b1) begin
        miscompares++;
        $display("FAIL underrun_tick: sample_out=%h underrun=%b, expected 0000/1",
                 sample_out, underrun);
      end
    end
    if (fill_level > 11'd1024) begin
      miscompares++;
      $display("FAIL fifo_overflow: fill_level=%0d exceeds 1024", fill_level);
    end
  end

  function automatic int model_fill();
    int n = 0;
    foreach (sb[i]) if (sb[i].stamp <= cyc) n++;
    return n;
  endfunction

  function automatic logic [7:0] byte_val(int i);
    case (i)
      0:       return 8'h34;
      1:       return 8'h12;
      2:       return 8'hCD;
      3:       return 8'hAB;
      default: return 8'((i * 37 + blk_seed) & 255);
    endcase
  endfunction

  task automatic request_block(input logic [AB-1:0] addr);
    bit ok = 0;
    @(negedge clk);
    #1 card_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (read_trigger === 1'b1) begin ok = 1; break; end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL trigger_timeout: read_trigger=%b, expected 1 within 50 cycles", read_trigger);
    end
    vectors++;
    if (block_addr !== addr) begin
      miscompares++;
      $display("FAIL trigger_addr: block_addr=%h, expected %h", block_addr, addr);
    end
    #1 card_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (read_trigger !== 1'b0) begin
      miscompares++;
      $display("FAIL trigger_width: read_trigger=%b, expected 0", read_trigger);
    end
  endtask

  // Enter at a negedge; one byte per cycle; returns at negedge+1 after the last byte.
  task automatic feed_block(input int n, input int drop_at, input bit model);
    logic [7:0] b;
    logic [7:0] lo = 8'h00;
    blk_seed += 11;
    for (int i = 0; i < n; i++) begin
      #1;
      b        = byte_val(i);
      data_in  = b;
      data_idx = IB'(i);
      data_new = 1'b1;
      if (i == drop_at) enable = 1'b0;
      if (i[0] == 1'b0) lo = b;
      else if (model) sb.push_back('{s: {b, lo}, stamp: cyc + 1});
      @(negedge clk);
    end
    #1 data_new = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; card_ready = 1'b0; data_new = 1'b0;
    data_in = 8'h00; data_idx = '0; start_block = 32'h100;
    repeat (3) @(negedge clk);
    vectors++;
    if (read_trigger !== 1'b0) begin miscompares++; $display("FAIL rst_trigger: got %b, expected 0", read_trigger); end
    vectors++;
    if (block_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %h, expected 0", block_addr); end
    vectors++;
    if (sample_out !== 16'h0) begin miscompares++; $display("FAIL rst_sample: got %h, expected 0", sample_out); end
    vectors++;
    if (sample_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b, expected 0", sample_valid); end
    vectors++;
    if (underrun !== 1'b0) begin miscompares++; $display("FAIL rst_underrun: got %b, expected 0", underrun); end
    vectors++;
    if (fill_level !== 11'd0) begin miscompares++; $display("FAIL rst_fill: got %0d, expected 0", fill_level); end
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (block_addr !== 32'h100) begin miscompares++; $display("FAIL idle_load_addr: got %h, expected 100", block_addr); end
  endtask

  task automatic test_first_block();
    int t0;
    #1 enable = 1'b1;
    t0 = trig_cnt;
    request_block(32'h100);
    feed_block(512, -1, 1);
    vectors++;
    if (block_addr !== 32'h101) begin miscompares++; $display("FAIL block_addr_inc: got %h, expected 101", block_addr); end
    vectors++;
    if (fill_level !== 11'(model_fill())) begin miscompares++; $display("FAIL first_fill: got %0d, expected %0d", fill_level, model_fill()); end
    vectors++;
    if (underrun !== 1'b0) begin miscompares++; $display("FAIL first_underrun: got %b, expected 0", underrun); end
    vectors++;
    if (trig_cnt - t0 !== 1) begin miscompares++; $display("FAIL first_trig_count: got %0d, expected 1", trig_cnt - t0); end
    exp_addr = 32'h101;
  endtask

  task automatic test_playback();
    longint c0 = 0, c1 = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (sample_valid === 1'b1) begin c0 = cyc; break; end end
    @(negedge clk);
    vectors++;
    if (sample_valid !== 1'b0) begin miscompares++; $display("FAIL valid_width: got %b, expected 0", sample_valid); end
    for (int i = 0; i < 20; i++) begin if (sample_valid === 1'b1) begin c1 = cyc; break; end @(negedge clk); end
    vectors++;
    if (c1 - c0 !== longint'(CLK_DIV)) begin miscompares++; $display("FAIL tick_period: got %0d, expected %0d", c1 - c0, CLK_DIV); end
  endtask

  task automatic test_fill_limit();
    int  guard = 0;
    int  t0;
    bit  ok = 0;
    while (model_fill() < 769 && guard < 8) begin
      request_block(exp_addr);
      feed_block(512, -1, 1);
      exp_addr++;
      guard++;
    end
    vectors++;
    if (fill_level !== 11'(model_fill()) || fill_level < 11'd769) begin
      miscompares++;
      $display("FAIL high_fill: got %0d, expected %0d (>=769)", fill_level, model_fill());
    end
    t0 = trig_cnt;
    #1 card_ready = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (read_trigger === 1'b1) begin ok = 1; break; end
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL refill_timeout: no read_trigger within 3000 cycles"); end
    vectors++;
    if (fill_level !== 11'd768) begin miscompares++; $display("FAIL refill_level: got %0d at trigger, expected 768", fill_level); end
    vectors++;
    if (block_addr !== exp_addr) begin miscompares++; $display("FAIL refill_addr: got %h, expected %h", block_addr, exp_addr); end
    #1 card_ready = 1'b0;
    @(negedge clk);
    feed_block(512, -1, 1);
    exp_addr++;
    vectors++;
    if (trig_cnt - t0 !== 1) begin miscompares++; $display("FAIL refill_trig_count: got %0d, expected 1", trig_cnt - t0); end
  endtask

  task automatic test_underrun();
    bit     ok = 0;
    longint c0 = 0, c1 = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (underrun === 1'b1) begin ok = 1; c0 = cyc; break; end
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL underrun_timeout: underrun never set"); end
    vectors++;
    if (sample_valid !== 1'b1 || sample_out !== 16'h0) begin
      miscompares++;
      $display("FAIL underrun_first: valid=%b sample=%h, expected 1/0000", sample_valid, sample_out);
    end
    vectors++;
    if (fill_level !== 11'd0) begin miscompares++; $display("FAIL underrun_fill: got %0d, expected 0", fill_level); end
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (sample_valid === 1'b1) begin c1 = cyc; break; end end
    vectors++;
    if (c1 - c0 !== longint'(CLK_DIV)) begin miscompares++; $display("FAIL underrun_period: got %0d, expected %0d", c1 - c0, CLK_DIV); end
    repeat (20) @(negedge clk);
    vectors++;
    if (underrun !== 1'b1) begin miscompares++; $display("FAIL underrun_sticky: got %b, expected 1", underrun); end
    #1 enable = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (underrun !== 1'b0) begin miscompares++; $display("FAIL underrun_clear: got %b, expected 0", underrun); end
    vectors++;
    if (sample_out !== 16'h0) begin miscompares++; $display("FAIL disable_sample: got %h, expected 0", sample_out); end
    vectors++;
    if (block_addr !== 32'h100) begin miscompares++; $display("FAIL rewind_addr: got %h, expected 100", block_addr); end
    sb.delete();
  endtask

  task automatic test_enable_drop();
    #1 enable = 1'b1;
    request_block(32'h100);
    feed_block(512, 200, 1);
    vectors++;
    if (block_addr !== 32'h101) begin miscompares++; $display("FAIL drop_block_done: got %h, expected 101", block_addr); end
    vectors++;
    if (fill_level !== 11'(model_fill())) begin miscompares++; $display("FAIL drop_block_fill: got %0d, expected %0d", fill_level, model_fill()); end
    repeat (2) @(negedge clk);
    vectors++;
    if (fill_level !== 11'd0) begin miscompares++; $display("FAIL drop_flush: got %0d, expected 0", fill_level); end
    vectors++;
    if (block_addr !== 32'h100) begin miscompares++; $display("FAIL drop_rewind: got %h, expected 100", block_addr); end
    vectors++;
    if (sample_out !== 16'h0 || sample_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_output: sample=%h valid=%b, expected 0000/0", sample_out, sample_valid);
    end
    sb.delete();
  endtask

  task automatic test_reset_mid_block();
    #1 enable = 1'b1;
    request_block(32'h100);
    feed_block(100, -1, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    sb.delete();
    vectors++;
    if (fill_level !== 11'd0 || block_addr !== 32'h0 || read_trigger !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_state: fill=%0d addr=%h trig=%b, expected 0/0/0", fill_level, block_addr, read_trigger);
    end
    vectors++;
    if (sample_out !== 16'h0 || sample_valid !== 1'b0 || underrun !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_out: sample=%h valid=%b underrun=%b, expected 0/0/0", sample_out, sample_valid, underrun);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    feed_block(20, -1, 0);
    vectors++;
    if (fill_level !== 11'd0) begin miscompares++; $display("FAIL midrst_ignore: got %0d, expected 0", fill_level); end
    #1 enable = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (block_addr !== 32'h100) begin miscompares++; $display("FAIL midrst_reload: got %h, expected 100", block_addr); end
  endtask

  task automatic test_addr_wrap();
    #1 start_block = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    vectors++;
    if (block_addr !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL wrap_load: got %h, expected ffffffff", block_addr); end
    #1 enable = 1'b1;
    request_block(32'hFFFF_FFFF);
    feed_block(512, -1, 1);
    vectors++;
    if (block_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_addr: got %h, expected 0", block_addr); end
    vectors++;
    if (fill_level !== 11'(model_fill())) begin miscompares++; $display("FAIL wrap_fill: got %0d, expected %0d", fill_level, model_fill()); end
    #1 enable = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
    vectors++;
    if (fill_level !== 11'd0) begin miscompares++; $display("FAIL wrap_flush: got %0d, expected 0", fill_level); end
  endtask

  initial begin
    test_reset();
    test_first_block();
    test_playback();
    test_fill_limit();
    test_underrun();
    test_enable_drop();
    test_reset_mid_block();
    test_addr_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded 1 ms");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sd_sample_stream.md
# sd_sample_stream

Downstream consumer of the SD card reader's block-read byte stream. Requests consecutive 512-byte blocks, packs the bytes into 16-bit little-endian signed PCM samples, buffers them in a sample FIFO, and releases one sample per sample-rate tick to the audio output stage. It sits between `SDCard_reader` and the DAC/PWM driver in the sound player top level.

## Interface
Parameters:
- `CLK_DIV`, 1134 — clk cycles per output sample (50 MHz / 1134 ≈ 44.09 kHz).
- `FIFO_AW`, 10 — log2 of FIFO depth in samples (1024).
- `ADDR_BITS`, 32 — block address width; equals `SD_BLOCK_ADDR_BITS`.
- `IDX_BITS`, 9 — byte index width; equals `SD_BLOCK_LENGHT_BITS`.

Ports:
- `clk`  in  1  — single clock (50 MHz); all logic on its rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `enable`  in  1  — playback enable; low = stop, flush, rewind.
- `start_block`  in  ADDR_BITS  — first block address of the sound file.
- `card_ready`  in  1  — reader idle and able to accept a trigger.
- `read_trigger`  out  1  — one-cycle block read request.
- `block_addr`  out  ADDR_BITS  — address of block being or about to be requested.
- `data_in`  in  8  — byte from reader.
- `data_idx`  in  IDX_BITS  — byte position 0..511 within block.
- `data_new`  in  1  — one-cycle strobe: `data_in`/`data_idx` valid.
- `sample_out`  out  16  — signed PCM sample, held between ticks.
- `sample_valid`  out  1  — one-cycle strobe at each sample tick.
- `underrun`  out  1  — sticky: a tick found the FIFO empty.
- `fill_level`  out  FIFO_AW+1  — samples currently in FIFO.

## Operation
- Reset values: `read_trigger`=0, `block_addr`=`start_block` (loaded on first enable-low IDLE cycle; 0 out of reset), `sample_out`=0, `sample_valid`=0, `underrun`=0, `fill_level`=0, state IDLE, divider 0.
- FSM states: IDLE, REQUEST, RECEIVE.
  - IDLE, `enable`=0: FIFO flushed, `block_addr`←`start_block`, `underrun`←0, divider held at 0.
  - IDLE → REQUEST when `enable`=1, `card_ready`=1, and free space (2^FIFO_AW − `fill_level`) ≥ 256.
  - REQUEST: `read_trigger`=1 for exactly this one cycle; → RECEIVE.
  - RECEIVE: on `data_new` with `data_idx[0]`=0 latch low byte; with `data_idx[0]`=1 push {`data_in`, low byte} to FIFO. On `data_new` with `data_idx`=511: push final sample, `block_addr`←`block_addr`+1 (wraps modulo 2^ADDR_BITS), → IDLE.
  - `enable` falling during RECEIVE: block completes normally (reader is not aborted), then IDLE flushes.
- Playback: divider counts 0..CLK_DIV−1 while `enable`=1. On wrap: if FIFO non-empty pop head into `sample_out`; if empty, `sample_out`←0 and `underrun`←1. `sample_valid` pulses on every wrap either way. `enable`=0 forces `sample_out`←0.
- Simultaneous push and pop: both occur, `fill_level` unchanged.
- Push while full cannot occur given the 256-free rule; if it does, the sample is dropped and `fill_level` saturates (flagged by bench assertion).

## Timing
- `read_trigger` asserted the cycle after IDLE decision (registered).
- Push: FIFO write and `fill_level` increment visible the cycle after the odd-index `data_new`.
- Pop: `sample_out` and `sample_valid` update the cycle after divider reaches CLK_DIV−1; a sample pushed ≥1 cycle earlier is poppable.
- `rst` mid-block: immediate return to reset values; in-flight bytes are ignored until the next REQUEST.

## Structure
- Shared package `sound_player_pkg`: `SAMPLE_BITS`=16, `SAMPLES_PER_BLOCK`=256, FSM state enum; address and index widths reuse the existing SD reader constants.
- Sub-module `sample_fifo`: synchronous show-ahead FIFO, depth 2^FIFO_AW × 16, with push, pop, flush, and count.

## Test plan
- Reset then `enable`=1, `card_ready`=1, `start_block`=0x100 → single `read_trigger` pulse, `block_addr`=0x100.
- Feed block bytes 0x34,0x12,0xCD,0xAB,… → FIFO holds 0x1234, 0xABCD in order; after idx 511, `block_addr`=0x101 and `fill_level`=256.
- With `CLK_DIV`=8 and FIFO preloaded → `sample_valid` every 8 cycles, `sample_out` 0x1234 then 0xABCD.
- Withhold data so FIFO drains → tick gives `sample_out`=0, `sample_valid`=1, `underrun`=1 stays set until `enable`=0.
- FIFO at 769 samples → no `read_trigger` until one pop brings free space to 256; then exactly one trigger.
- Drop `enable` at byte 200 → block finishes, then FIFO flushed, `fill_level`=0, `block_addr`=`start_block`.
